my_clint: RTL and testbench
===========================

// Module: my_clint
// PURPOSE
//  Core-Local Interruptor (RISC-V CLINT) for an N-core system. Holds a free-running 64-bit
//  mtime counter advanced by an external real-time tick, per-hart 64-bit mtimecmp and msip
//  registers, and drives per-hart machine timer (mtip) and software (msip) interrupt lines.
//  Sits on the CPU native valid/ready bus as a memory-mapped peripheral.
// PARAMETERS
//  ADDR_W   16  byte-address width; must be >=16 (map reaches 0xBFFF)
//  DATA_W   32  bus data width; only 32 supported
//  N_CORES  1   number of harts (1..16); sets mtip/msip width and register count
// PORTS
//  clk      in  1         system clock; all logic on posedge clk
//  reset    in  1         asynchronous, active-low reset (asserted when 0)
//  rt_clk   in  1         real-time clock, asynchronous to clk; treated as data, not a clock
//  valid    in  1         request strobe
//  address  in  ADDR_W    byte address
//  wdata    in  DATA_W    write data
//  wstrb    in  DATA_W/8  byte enables; nonzero = write, all-zero = read
//  rdata    out DATA_W    read data, valid when ready=1
//  ready    out 1         request completion
//  mtip     out N_CORES   timer interrupt pending, one per hart
//  msip     out N_CORES   software interrupt pending, one per hart
// BEHAVIOUR
//  Register map (word-aligned, address[1:0] ignored):
//   0x0000+4*h  msip[h]      bit0 RW, bits31:1 read 0
//   0x4000+8*h  mtimecmp[h]  low word; +4 high word
//   0xBFF8      mtime low word; 0xBFFC mtime high word
//   any other address: reads 0, writes ignored, still acknowledged
//  Handshake: valid sampled at posedge; ready=1 exactly one cycle later for one cycle; rdata
//   valid in that cycle, 0 otherwise. Master holds valid until ready; back-to-back requests
//   allowed (new valid in the cycle after ready). Write takes effect at the same edge that
//   raises ready. Byte strobes apply per byte to the addressed 32-bit half.
//  Time base: rt_clk passed through 2-FF synchronizer plus edge-detect FF; each synchronized
//   rising edge increments mtime by 1 (one-cycle tick). Requires f(clk) > 2*f(rt_clk).
//   mtime wraps 0xFFFF_FFFF_FFFF_FFFF -> 0. Reads of low then high words are not atomic.
//  Collision: bus write to mtime in the same cycle as a tick -> written value wins, tick lost.
//  mtip[h] = registered (mtime >= mtimecmp[h]), unsigned 64-bit; updates 1 cycle after the
//   mtime/mtimecmp change; stays high until mtimecmp raised above mtime or mtime wraps.
//  msip[h] = msip register bit0, direct from flop.
//  Reset (reset=0, async): mtime=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, msip regs=0,
//   mtip=0, msip=0, ready=0, rdata=0, synchronizer=0. Reset mid-transaction aborts it, no ready.
// TESTING
//  Reset: hold reset=0 100 cycles -> mtip=0, msip=0, ready=0; read 0xBFF8 after release ->
//   small value (ticks since release), 0x4000/0x4004 read 0xFFFFFFFF.
//  Handshake: read 0x0000 -> ready high exactly 1 cycle after valid, rdata=0; read 0x2000
//   (unmapped) -> ready, rdata=0.
//  Software IRQ: write 0x0000=1 -> msip[0]=1 next cycle; write 0x0000=0 -> msip[0]=0; read
//   back 0xFFFFFFFF write -> rdata=0x00000001.
//  Timer IRQ: write 0x4004=0, 0x4000=20 -> mtip[0]=0 until mtime>=20, then 1; write 0x4000=
//   0xFFFFFFFF, 0x4004=0xFFFFFFFF -> mtip[0]=0 one cycle later.
//  Counter: write 0xBFFC=0xFFFFFFFF, 0xBFF8=0xFFFFFFFE; after 2 rt_clk edges read 0xBFFC=0,
//   0xBFF8=0 (wrap); mtime write coinciding with tick keeps written value.
//  Strobes: write 0x4000=0xAABBCCDD wstrb=0b0010 onto 0xFFFFFFFF -> reads 0xFFFFCCFF.

Source files
------------

// File: rtl/my_clint.sv
// Core-Local Interruptor for an N-hart RISC-V system.
// Holds a 64-bit mtime counter advanced by a synchronized real-time tick,
// plus per-hart mtimecmp and msip registers. It drives per-hart timer (mtip)
// and software (msip) interrupt lines and is accessed over a valid/ready bus.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   rt_clk   real-time reference, asynchronous to clk (sampled as data)
//   valid    request strobe, held by the master until ready
//   address  byte address (address[1:0] ignored)
//   wdata    write data
//   wstrb    byte enables; nonzero = write, zero = read
//   rdata    read data, valid while ready=1, zero otherwise
//   ready    one-cycle completion pulse, one cycle after valid is sampled
//   mtip     timer interrupt pending, one bit per hart
//   msip     software interrupt pending, one bit per hart
//
// Register map (word-aligned):
//   0x0000 + 4*h  msip[h]          bit0 RW
//   0x4000 + 8*h  mtimecmp[h] lo   +4 hi
//   0xBFF8        mtime lo         0xBFFC hi
//   other         read 0, write ignored, still acknowledged
module my_clint #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned N_CORES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rt_clk,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   output logic [N_CORES-1:0]    mtip,
   output logic [N_CORES-1:0]    msip
);

   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned WA_W     = ADDR_W - 2;
   localparam int unsigned TIME_W   = 64;
   localparam int unsigned CMP_BASE = 32'h1000;  // 0x4000 as word address
   localparam int unsigned TIME_LO  = 32'h2FFE;  // 0xBFF8 as word address
   localparam int unsigned TIME_HI  = 32'h2FFF;  // 0xBFFC as word address

   // Per-byte merge of write data into one 32-bit half of a register.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_val,
      input logic [DATA_W-1:0] new_val,
      input logic [STRB_W-1:0] strb
   );
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   logic [TIME_W-1:0]  mtime_q;
   logic [TIME_W-1:0]  mtimecmp_q [N_CORES];

   logic               rt_s1;
   logic               rt_s2;
   logic               rt_d;
   logic               tick_c;

   logic [WA_W-1:0]    word_addr_c;
   logic               accept_c;
   logic               wr_en_c;
   logic [N_CORES-1:0] sel_msip_c;
   logic [N_CORES-1:0] sel_cmp_lo_c;
   logic [N_CORES-1:0] sel_cmp_hi_c;
   logic               sel_time_lo_c;
   logic               sel_time_hi_c;
   logic [DATA_W-1:0]  rdata_c;
   logic               unused_addr_bits;

   assign word_addr_c      = address[ADDR_W-1:2];
   assign unused_addr_bits = ^address[1:0];

   // A request is taken only while no response is outstanding, so a held
   // valid during the ready cycle is not accepted twice.
   assign accept_c = valid & ~ready;
   assign wr_en_c  = accept_c & (|wstrb);

   // Real-time input synchronizer and rising-edge detect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rt_s1 <= 1'b0;
         rt_s2 <= 1'b0;
         rt_d  <= 1'b0;
      end else begin
         rt_s1 <= rt_clk;
         rt_s2 <= rt_s1;
         rt_d  <= rt_s2;
      end
   end

   assign tick_c = rt_s2 & ~rt_d;

   // Address decode to one-hot register selects.
   always_comb begin
      sel_msip_c    = '0;
      sel_cmp_lo_c  = '0;
      sel_cmp_hi_c  = '0;
      sel_time_lo_c = (word_addr_c == WA_W'(TIME_LO));
      sel_time_hi_c = (word_addr_c == WA_W'(TIME_HI));
      for (int unsigned h = 0; h < N_CORES; h++) begin
         sel_msip_c[h]   = (word_addr_c == WA_W'(h));
         sel_cmp_lo_c[h] = (word_addr_c == WA_W'(CMP_BASE + 2*h));
         sel_cmp_hi_c[h] = (word_addr_c == WA_W'(CMP_BASE + 2*h + 1));
      end
   end

   // Read mux; unmapped addresses fall through to zero.
   always_comb begin
      rdata_c = '0;
      for (int unsigned h = 0; h < N_CORES; h++) begin
         if (sel_msip_c[h])   rdata_c = DATA_W'(msip[h]);
         if (sel_cmp_lo_c[h]) rdata_c = mtimecmp_q[h][31:0];
         if (sel_cmp_hi_c[h]) rdata_c = mtimecmp_q[h][63:32];
      end
      if (sel_time_lo_c) rdata_c = mtime_q[31:0];
      if (sel_time_hi_c) rdata_c = mtime_q[63:32];
   end

   // Bus response: one-cycle ready pulse with data, zero data otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready <= 1'b0;
         rdata <= '0;
      end else begin
         ready <= accept_c;
         rdata <= accept_c ? rdata_c : '0;
      end
   end

   // mtime: a bus write to either half wins over a coincident tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtime_q <= '0;
      end else if (wr_en_c && sel_time_lo_c) begin
         mtime_q[31:0] <= merge_bytes(mtime_q[31:0], wdata, wstrb);
      end else if (wr_en_c && sel_time_hi_c) begin
         mtime_q[63:32] <= merge_bytes(mtime_q[63:32], wdata, wstrb);
      end else if (tick_c) begin
         mtime_q <= mtime_q + TIME_W'(1);
      end
   end

   // Per-hart mtimecmp and msip registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned h = 0; h < N_CORES; h++) begin
            mtimecmp_q[h] <= '1;
         end
         msip <= '0;
      end else if (wr_en_c) begin
         for (int unsigned h = 0; h < N_CORES; h++) begin
            if (sel_cmp_lo_c[h]) begin
               mtimecmp_q[h][31:0] <= merge_bytes(mtimecmp_q[h][31:0], wdata, wstrb);
            end
            if (sel_cmp_hi_c[h]) begin
               mtimecmp_q[h][63:32] <= merge_bytes(mtimecmp_q[h][63:32], wdata, wstrb);
            end
            if (sel_msip_c[h] && wstrb[0]) begin
               msip[h] <= wdata[0];
            end
         end
      end
   end

   // Timer interrupt: registered unsigned compare, one cycle behind its inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtip <= '0;
      end else begin
         for (int unsigned h = 0; h < N_CORES; h++) begin
            mtip[h] <= (mtime_q >= mtimecmp_q[h]);
         end
      end
   end

endmodule

// File: tb/tb_my_clint.sv
// Self-checking bench for my_clint with three harts. A behavioural model
// tracks mtime as a plain 64-bit count of rt_clk pulses and the registers
// as arrays; expected read data and interrupt lines come from that model.
module tb_my_clint;

   localparam int NC = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rt_clk = 1'b0;
   logic          valid = 1'b0;
   logic [15:0]   address = '0;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic [31:0]   rdata;
   logic          ready;
   logic [NC-1:0] mtip;
   logic [NC-1:0] msip;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0]   m_time;
   logic [63:0]   m_cmp [NC];
   logic [NC-1:0] m_msip;

   my_clint #(.ADDR_W(16), .DATA_W(32), .N_CORES(NC)) dut (
      .clk     (clk),
      .reset   (reset),
      .rt_clk  (rt_clk),
      .valid   (valid),
      .address (address),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rdata   (rdata),
      .ready   (ready),
      .mtip    (mtip),
      .msip    (msip)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d,
                                       input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_time = '0;
      m_msip = '0;
      for (int h = 0; h < NC; h++) m_cmp[h] = '1;
   endtask

   function automatic logic [31:0] model_read(input logic [15:0] a);
      int w;
      int h;
      w = int'(a) & 'hFFFC;
      if (w < 4*NC) return {31'b0, m_msip[w/4]};
      if (w >= 'h4000 && w < 'h4000 + 8*NC) begin
         h = (w - 'h4000) / 8;
         return ((w % 8) == 4) ? m_cmp[h][63:32] : m_cmp[h][31:0];
      end
      if (w == 'hBFF8) return m_time[31:0];
      if (w == 'hBFFC) return m_time[63:32];
      return 32'h0;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      int w;
      int h;
      w = int'(a) & 'hFFFC;
      if (s == 4'b0) return;
      if (w < 4*NC) begin
         if (s[0]) m_msip[w/4] = d[0];
      end else if (w >= 'h4000 && w < 'h4000 + 8*NC) begin
         h = (w - 'h4000) / 8;
         if ((w % 8) == 4) m_cmp[h][63:32] = mrg(m_cmp[h][63:32], d, s);
         else              m_cmp[h][31:0]  = mrg(m_cmp[h][31:0], d, s);
      end else if (w == 'hBFF8) begin
         m_time[31:0] = mrg(m_time[31:0], d, s);
      end else if (w == 'hBFFC) begin
         m_time[63:32] = mrg(m_time[63:32], d, s);
      end
   endtask

   function automatic logic [NC-1:0] exp_mtip();
      logic [NC-1:0] r;
      for (int h = 0; h < NC; h++) r[h] = (m_time >= m_cmp[h]);
      return r;
   endfunction

   // ---------------- bus / stimulus helpers ----------------
   // One transaction; lat = cycles from valid to ready (0 if ready never came).
   task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat);
      @(negedge clk);
      valid = 1'b1; address = a; wdata = d; wstrb = s;
      lat = 0; rd = '0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (ready) begin lat = i; rd = rdata; break; end
      end
      @(negedge clk);
      valid = 1'b0; wstrb = '0;
      model_write(a, d, s);
   endtask

   task automatic rt_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); rt_clk = 1'b1;
         repeat (3) @(negedge clk);
         rt_clk = 1'b0;
         repeat (2) @(negedge clk);
         m_time = m_time + 64'd1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] rd;
      int lat;
      reset = 1'b0;
      model_reset();
      repeat (100) @(posedge clk);
      #1;
      n_cmp++; if (mtip !== '0) begin n_err++; $display("FAIL reset_mtip: got %b want 0", mtip); end
      n_cmp++; if (msip !== '0) begin n_err++; $display("FAIL reset_msip: got %b want 0", msip); end
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      @(negedge clk); reset = 1'b1;
      repeat (3) @(negedge clk);
      bus(16'hBFF8, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== model_read(16'hBFF8) || lat !== 1)
         begin n_err++; $display("FAIL reset_mtime: got %h lat %0d want %h lat 1", rd, lat, model_read(16'hBFF8)); end
      bus(16'h4000, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_cmp_lo: got %h want ffffffff", rd); end
      bus(16'h4004, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_cmp_hi: got %h want ffffffff", rd); end
   endtask

   task automatic test_handshake();
      logic [31:0] rd;
      int lat;
      bus(16'h0000, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (lat !== 1 || rd !== 32'h0)
         begin n_err++; $display("FAIL hs_read0: lat %0d data %h want lat 1 data 0", lat, rd); end
      @(posedge clk); #1;
      n_cmp++; if (ready !== 1'b0 || rdata !== 32'h0)
         begin n_err++; $display("FAIL hs_ready_pulse: ready %b rdata %h want 0 0", ready, rdata); end
      bus(16'h2000, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (lat !== 1 || rd !== 32'h0)
         begin n_err++; $display("FAIL hs_unmapped: lat %0d data %h want lat 1 data 0", lat, rd); end
   endtask

   task automatic test_sw_irq();
      logic [31:0] rd;
      int lat;
      bus(16'h0000, 32'h1, 4'hF, rd, lat);
      n_cmp++; if (msip !== m_msip || msip[0] !== 1'b1)
         begin n_err++; $display("FAIL sw_set: got %b want %b", msip, m_msip); end
      bus(16'h0000, 32'h0, 4'hF, rd, lat);
      n_cmp++; if (msip !== 3'b000) begin n_err++; $display("FAIL sw_clear: got %b want 000", msip); end
      bus(16'h0000, 32'hFFFF_FFFF, 4'hF, rd, lat);
      bus(16'h0000, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL sw_readback: got %h want 00000001", rd); end
      bus(16'h0008, 32'h1, 4'hF, rd, lat);
      n_cmp++; if (msip !== 3'b101) begin n_err++; $display("FAIL sw_hart2: got %b want 101", msip); end
   endtask

   task automatic test_timer();
      logic [31:0] rd;
      int lat;
      bus(16'hBFFC, 32'h0, 4'hF, rd, lat);
      bus(16'hBFF8, 32'h0, 4'hF, rd, lat);
      bus(16'h4004, 32'h0, 4'hF, rd, lat);
      bus(16'h4000, 32'd20, 4'hF, rd, lat);
      rt_pulses(19);
      n_cmp++; if (mtip !== exp_mtip() || mtip[0] !== 1'b0)
         begin n_err++; $display("FAIL timer_below: got %b want %b", mtip, exp_mtip()); end
      rt_pulses(1);
      n_cmp++; if (mtip !== exp_mtip() || mtip[0] !== 1'b1)
         begin n_err++; $display("FAIL timer_equal: got %b want %b", mtip, exp_mtip()); end
      rt_pulses(3);
      n_cmp++; if (mtip[0] !== 1'b1) begin n_err++; $display("FAIL timer_above: got %b want 1", mtip[0]); end
      bus(16'h4000, 32'hFFFF_FFFF, 4'hF, rd, lat);
      bus(16'h4004, 32'hFFFF_FFFF, 4'hF, rd, lat);
      @(posedge clk); #1;
      n_cmp++; if (mtip !== 3'b000) begin n_err++; $display("FAIL timer_clear: got %b want 000", mtip); end
   endtask

   task automatic test_counter();
      logic [31:0] rd;
      int lat;
      bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, lat);
      bus(16'hBFF8, 32'hFFFF_FFFE, 4'hF, rd, lat);
      rt_pulses(1);
      n_cmp++; if (mtip !== 3'b111) begin n_err++; $display("FAIL cnt_allones_mtip: got %b want 111", mtip); end
      rt_pulses(1);
      n_cmp++; if (mtip !== 3'b000) begin n_err++; $display("FAIL cnt_wrap_mtip: got %b want 000", mtip); end
      bus(16'hBFFC, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL cnt_wrap_hi: got %h want 0", rd); end
      bus(16'hBFF8, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL cnt_wrap_lo: got %h want 0", rd); end
   endtask

   // rt_clk rises two negedges before valid, so its tick lands on the accept edge.
   task automatic test_collision();
      logic [31:0] rd;
      int lat;
      bus(16'hBFF8, 32'h0000_0100, 4'hF, rd, lat);
      @(negedge clk); rt_clk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      valid = 1'b1; address = 16'hBFF8; wdata = 32'h0000_5555; wstrb = 4'hF;
      @(posedge clk); #1;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL coll_ready: got %b want 1", ready); end
      @(negedge clk); valid = 1'b0; wstrb = '0;
      m_time[31:0] = 32'h0000_5555;
      repeat (3) @(negedge clk);
      rt_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus(16'hBFF8, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== model_read(16'hBFF8) || rd !== 32'h0000_5555)
         begin n_err++; $display("FAIL coll_write_wins: got %h want 00005555", rd); end
   endtask

   task automatic test_strobes();
      logic [31:0] rd;
      int lat;
      bus(16'h4000, 32'hFFFF_FFFF, 4'hF, rd, lat);
      bus(16'h4000, 32'hAABB_CCDD, 4'b0010, rd, lat);
      bus(16'h4000, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'hFFFF_CCFF) begin n_err++; $display("FAIL strb_byte1: got %h want ffffccff", rd); end
      bus(16'h400C, 32'h1234_5678, 4'b1001, rd, lat);
      bus(16'h400C, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== model_read(16'h400C))
         begin n_err++; $display("FAIL strb_hart1_hi: got %h want %h", rd, model_read(16'h400C)); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int lat1;
      int lat2;
      bus(16'h4010, 32'h0BAD_F00D, 4'hF, rd, lat1);
      bus(16'h4010, 32'h0, 4'h0, rd, lat2);
      n_cmp++; if (lat1 !== 1 || lat2 !== 1 || rd !== 32'h0BAD_F00D)
         begin n_err++; $display("FAIL b2b: lat %0d/%0d data %h want 1/1 0badf00d", lat1, lat2, rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd;
      logic [31:0] exp_rd;
      logic [31:0] d;
      logic [3:0]  s;
      logic [15:0] a;
      int lat;
      int h;
      for (int it = 0; it < 200; it++) begin
         h = int'($urandom_range(0, NC-1));
         d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
         s = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0: a = 16'(4*h);
            1: a = 16'('h4000 + 8*h);
            2: begin a = 16'('h4004 + 8*h); if ($urandom_range(0, 3) != 0) d = 32'h0; end
            3: a = 16'hBFF8;
            4: begin a = 16'hBFFC; if ($urandom_range(0, 3) != 0) d = 32'h0; end
            5: case ($urandom_range(0, 4))
                  0: a = 16'h2000;
                  1: a = 16'(4*NC);
                  2: a = 16'('h4000 + 8*NC);
                  3: a = 16'h8000;
                  default: a = 16'hBFF4;
               endcase
            default: a = 16'hFFFF;
         endcase
         if (a == 16'hFFFF) begin
            rt_pulses(int'($urandom_range(1, 3)));
         end else begin
            a = a | 16'($urandom_range(0, 3));
            exp_rd = model_read(a);
            bus(a, d, s, rd, lat);
            n_cmp++; if (lat !== 1)
               begin n_err++; $display("FAIL rnd_lat it%0d addr %h: got %0d want 1", it, a, lat); end
            if (s == 4'h0) begin
               n_cmp++; if (rd !== exp_rd)
                  begin n_err++; $display("FAIL rnd_read it%0d addr %h: got %h want %h", it, a, rd, exp_rd); end
            end
            @(posedge clk); #1;
         end
         n_cmp++; if (mtip !== exp_mtip() || msip !== m_msip)
            begin n_err++; $display("FAIL rnd_irq it%0d: mtip %b msip %b want %b %b", it, mtip, msip, exp_mtip(), m_msip); end
      end
   endtask

   // Reset asserted before the edge that would accept a write: no ready, no write.
   task automatic test_reset_abort();
      logic [31:0] rd;
      int lat;
      bus(16'h0004, 32'h1, 4'hF, rd, lat);
      @(negedge clk);
      valid = 1'b1; address = 16'h4000; wdata = 32'h0000_0005; wstrb = 4'hF;
      #2 reset = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (ready !== 1'b0 || msip !== '0 || mtip !== '0)
         begin n_err++; $display("FAIL abort_outputs: ready %b msip %b mtip %b want 0 0 0", ready, msip, mtip); end
      @(negedge clk); valid = 1'b0; wstrb = '0;
      model_reset();
      @(negedge clk); reset = 1'b1;
      bus(16'h4000, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL abort_cmp: got %h want ffffffff", rd); end
      bus(16'h0004, 32'h0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL abort_msip: got %h want 0", rd); end
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_sw_irq();
      test_timer();
      test_counter();
      test_collision();
      test_strobes();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
